// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
//   byte_valid/byte_data : incoming byte stream (LSB of each word first)
//   byte_ready           : loader accepts a byte this cycle
//   mem_we/addr/wdata    : instruction memory write port
// master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream before the
// core runs, assembling little-endian 32-bit words and holding the fetch
// path off until the load completes.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle load request, honoured only when not busy
//   word_count   : words to load (saturates to DEPTH), sampled with start
//   bus (slave)  : byte stream handshake + memory write port
//   busy         : load in progress
//   done         : last load completed, held until the next start
//   core_hold    : keeps the core's PC/fetch stalled while high
//   checksum_ok  : (CHECKSUM_EN only) trailer matched the word sum
//
// Optional feature macro: CHECKSUM_EN. When defined, a 32-bit modular sum of
// all written words is compared with a 4-byte little-endian trailer received
// after the last word; core_hold stays high in DONE on a mismatch.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] word_count,
  imem_loader_if.slave        bus,
  output logic                busy,
  output logic                done,
  output logic                core_hold
`ifdef CHECKSUM_EN
  ,
  output logic                checksum_ok
`endif
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CHECK = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  core_hold_q, core_hold_d;
`ifdef CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
  logic                  ok_q, ok_d;
`endif

  logic                  byte_acc;
  logic                  last_word;
  logic [CNT_W-1:0]      n_start;
  logic [31:0]           full_word;

  // Handshake uses the registered ready, which is high only in RECV/CHECK.
  assign byte_acc  = bus.byte_valid & byte_ready_q;
  assign last_word = (CNT_W'(addr_q) == (n_q - CNT_W'(1)));
  assign n_start   = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
  // The 4th byte is the top byte; the lower three are already in word_q.
  assign full_word = {bus.byte_data, word_q};

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    addr_d      = addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef CHECKSUM_EN
    sum_d       = sum_q;
    ok_d        = ok_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d        = n_start;
          addr_d     = '0;
          byte_idx_d = '0;
`ifdef CHECKSUM_EN
          sum_d      = '0;
          ok_d       = 1'b0;
          // An empty load still expects the (zero) trailer.
          state_d    = (n_start == '0) ? S_CHECK : S_RECV;
`else
          state_d    = (n_start == '0) ? S_DONE : S_RECV;
`endif
        end
      end

      S_RECV: begin
        if (byte_acc) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.byte_data;
            2'd1: word_d[15:8]  = bus.byte_data;
            2'd2: word_d[23:16] = bus.byte_data;
            default: begin
              mem_addr_d  = addr_q;
              mem_wdata_d = full_word;
              state_d     = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        byte_idx_d = '0;
`ifdef CHECKSUM_EN
        sum_d = sum_q + mem_wdata_q;
`endif
        if (last_word) begin
`ifdef CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_RECV;
        end
      end

`ifdef CHECKSUM_EN
      S_CHECK: begin
        // sum_q already includes the final word: WRITE added it on exit.
        if (byte_acc) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.byte_data;
            2'd1: word_d[15:8]  = bus.byte_data;
            2'd2: word_d[23:16] = bus.byte_data;
            default: begin
              ok_d    = (sum_q == full_word);
              state_d = S_DONE;
            end
          endcase
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Outputs are a function of the next state so they register alongside it.
    byte_ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
    mem_we_d     = (state_d == S_WRITE);
    busy_d       = byte_ready_d | mem_we_d;
    done_d       = (state_d == S_DONE);
`ifdef CHECKSUM_EN
    core_hold_d  = ~(done_d & ok_d);
`else
    core_hold_d  = ~done_d;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      addr_q       <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_hold_q  <= 1'b1;
`ifdef CHECKSUM_EN
      sum_q        <= '0;
      ok_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_hold_q  <= core_hold_d;
`ifdef CHECKSUM_EN
      sum_q        <= sum_d;
      ok_q         <= ok_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign core_hold      = core_hold_q;
`ifdef CHECKSUM_EN
  assign checksum_ok    = ok_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a transaction-level model of the
// loader (expected word writes built from accepted bytes) is compared on
// every cycle, plus literal expectations for the directed loads.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic          core_hold;
`ifdef CHECKSUM_EN
  logic          checksum_ok;
`endif

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .core_hold  (core_hold)
`ifdef CHECKSUM_EN
    ,
    .checksum_ok(checksum_ok)
`endif
  );

  always #5 clk = ~clk;

  // Counters: monitor-side and driver-side.
  int checks_m = 0;
  int errors_m = 0;
  int checks_d = 0;
  int errors_d = 0;

  // Reference model state (owned by the monitor).
  int unsigned exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] mem_img [DEPTH];
  logic [31:0] m_word;
  logic [31:0] m_sum;
  logic [31:0] m_trl;
  int          m_n;
  int          m_acc;
  int          m_nwr;
  bit          m_active;

  // Byte source for the driver.
  logic [7:0]  src_q[$];

  // Per-cycle compare against the model; samples on the falling edge.
  always @(negedge clk) begin
    int unsigned a;
    logic [31:0] d;
    if (bus.mem_we === 1'b1) begin
      checks_m++;
      if (exp_data_q.size() == 0) begin
        errors_m++;
        $display("FAIL unexpected_write: addr=%0d data=%h required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        a = exp_addr_q.pop_front();
        d = exp_data_q.pop_front();
        if (bus.mem_addr !== AW'(a) || bus.mem_wdata !== d) begin
          errors_m++;
          $display("FAIL write_content: got addr=%0d data=%h required addr=%0d data=%h",
                   bus.mem_addr, bus.mem_wdata, a, d);
        end
        mem_img[bus.mem_addr] = bus.mem_wdata;
        m_nwr++;
        m_sum += d;
      end
    end else if (exp_data_q.size() != 0) begin
      checks_m++;
      errors_m++;
      $display("FAIL late_write: got mem_we=%b required 1 for addr=%0d",
               bus.mem_we, exp_addr_q[0]);
      exp_addr_q.delete();
      exp_data_q.delete();
    end

    checks_m++;
    if (busy !== (bus.byte_ready | bus.mem_we) || (bus.byte_ready & bus.mem_we) ||
        (busy & done)) begin
      errors_m++;
      $display("FAIL status_bits: got busy=%b ready=%b we=%b done=%b required consistent",
               busy, bus.byte_ready, bus.mem_we, done);
    end

    if (rst) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      m_active = 1'b0;
    end else if (start && !busy) begin
      m_n      = (int'(word_count) > int'(DEPTH)) ? int'(DEPTH) : int'(word_count);
      m_acc    = 0;
      m_nwr    = 0;
      m_sum    = '0;
      m_trl    = '0;
      m_active = 1'b1;
    end else if (bus.byte_valid && bus.byte_ready) begin
      checks_m++;
      if (!m_active) begin
        errors_m++;
        $display("FAIL accept_idle: got byte %h accepted required no acceptance",
                 bus.byte_data);
      end else if (m_acc < 4 * m_n) begin
        m_word[8*(m_acc%4) +: 8] = bus.byte_data;
        if (m_acc % 4 == 3) begin
          exp_addr_q.push_back(m_acc / 4);
          exp_data_q.push_back(m_word);
        end
        m_acc++;
`ifdef CHECKSUM_EN
      end else if (m_acc < 4 * m_n + 4) begin
        m_trl[8*(m_acc-4*m_n) +: 8] = bus.byte_data;
        m_acc++;
`endif
      end else begin
        errors_m++;
        $display("FAIL extra_byte: got byte %0d accepted required at most %0d",
                 m_acc + 1, m_acc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks_d++;
    if (act !== expv) begin
      errors_d++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) src_q.push_back(w[8*i +: 8]);
  endtask

  task automatic push_trailer(input logic [31:0] w);
`ifdef CHECKSUM_EN
    push_word(w);
`else
    if (w == 32'hFFFF_FFFF) src_q.push_back(8'h00);
`endif
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    chk("rst_busy",       32'(busy),           32'd0);
    chk("rst_done",       32'(done),           32'd0);
    chk("rst_core_hold",  32'(core_hold),      32'd1);
`ifdef CHECKSUM_EN
    chk("rst_checksum_ok", 32'(checksum_ok),   32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mode: 0 valid held high, 1 valid toggling, 2 random valid + stray starts.
  task automatic do_load(input int wc, input int mode, input int abort_at,
                         output int cyc, output bit timed_out);
    int nacc;
    bit acc;
    nacc       = 0;
    timed_out  = 1'b0;
    start      = 1'b1;
    word_count = CW'(wc);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1) begin
      if (cyc >= 800) begin
        timed_out = 1'b1;
        break;
      end
      if (abort_at > 0 && nacc == abort_at) break;
      if (src_q.size() > 0) begin
        bus.byte_data = src_q[0];
        case (mode)
          0:       bus.byte_valid = 1'b1;
          1:       bus.byte_valid = (cyc % 2 == 1);
          default: bus.byte_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        bus.byte_valid = 1'b0;
      end
      if (mode == 2) begin
        start      = ($urandom_range(0, 7) == 0);
        word_count = CW'($urandom_range(0, 15));
      end
      @(negedge clk);
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        void'(src_q.pop_front());
        nacc++;
      end
      cyc++;
    end
    start          = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  task automatic finish_load(input int wc, input int mode, input int cyc, input bit to);
    int  n;
    bit  ok;
    n = (wc > int'(DEPTH)) ? int'(DEPTH) : wc;
    chk("load_timeout", 32'(to),   32'd0);
    chk("load_done",    32'(done), 32'd1);
    chk("load_busy",    32'(busy), 32'd0);
    chk("load_nwrites", 32'(m_nwr), 32'(n));
`ifdef CHECKSUM_EN
    ok = (m_sum == m_trl);
    chk("load_checksum_ok", 32'(checksum_ok), 32'(ok));
    chk("load_core_hold",   32'(core_hold),   32'(!ok));
    if (mode == 0) chk("load_latency", 32'(cyc), 32'(5 * n + 5));
`else
    ok = 1'b1;
    chk("load_core_hold", 32'(core_hold), 32'(!ok));
    if (mode == 0) chk("load_latency", 32'(cyc), 32'(5 * n + 1));
`endif
  endtask

  initial begin
    int cyc;
    bit to;
    int wc;
    int mode;
    rst            = 1'b1;
    start          = 1'b0;
    word_count     = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    m_active       = 1'b0;
    m_n            = 0;
    m_acc          = 0;
    m_nwr          = 0;
    m_sum          = '0;
    m_trl          = '0;
    m_word         = '0;
    do_reset();
    idle(2);

    // Two words, valid held high: bytes 13 00 00 00 93 00 10 00.
    src_q.delete();
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    push_trailer(32'h0010_00A6);
    do_load(2, 0, 0, cyc, to);
    finish_load(2, 0, cyc, to);
    chk("t1_word0", mem_img[0], 32'h0000_0013);
    chk("t1_word1", mem_img[1], 32'h0010_0093);
`ifndef CHECKSUM_EN
    chk("t1_done_cycle", 32'(cyc), 32'd11);
    chk("t1_core_hold", 32'(core_hold), 32'd0);
`endif
    idle(3);

    // Empty load.
    src_q.delete();
    push_trailer(32'h0000_0000);
    do_load(0, 0, 0, cyc, to);
    finish_load(0, 0, cyc, to);
    chk("t2_nwrites", 32'(m_nwr), 32'd0);
`ifndef CHECKSUM_EN
    chk("t2_done_cycle", 32'(cyc), 32'd1);
`endif
    idle(2);

    // Oversized count saturates to DEPTH words.
    src_q.delete();
    repeat (40) src_q.push_back(8'($urandom));
    do_load(12, 0, 0, cyc, to);
    finish_load(12, 0, cyc, to);
    chk("t3_nwrites", 32'(m_nwr), 32'd8);
`ifndef CHECKSUM_EN
    chk("t3_left_bytes", 32'(src_q.size()), 32'd8);
`else
    chk("t3_left_bytes", 32'(src_q.size()), 32'd4);
`endif
    bus.byte_valid = 1'b1;
    idle(2);
    chk("t3_ready_after", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;

    // Toggling valid: EF BE AD DE.
    src_q.delete();
    push_word(32'hDEAD_BEEF);
    push_trailer(32'hDEAD_BEEF);
    do_load(1, 1, 0, cyc, to);
    finish_load(1, 1, cyc, to);
    chk("t4_word0", mem_img[0], 32'hDEAD_BEEF);
    idle(2);

    // Reset after 6 of 8 bytes, then reload from address 0.
    src_q.delete();
    push_word(32'hA5A5_0001);
    push_word(32'h1234_5678);
    do_load(2, 0, 6, cyc, to);
    chk("t5_writes_before_rst", 32'(m_nwr), 32'd1);
    do_reset();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t5_ready_after_rst", 32'(bus.byte_ready), 32'd0);
    end
    bus.byte_valid = 1'b0;
    src_q.delete();
    push_word(32'h4433_2211);
    push_word(32'h0BAD_F00D);
    push_word(32'h7777_0000);
    push_trailer(32'h0000_0000);
    do_load(3, 0, 0, cyc, to);
    finish_load(3, 0, cyc, to);
    chk("t5_word0", mem_img[0], 32'h4433_2211);
    chk("t5_word2", mem_img[2], 32'h7777_0000);
    idle(2);

`ifdef CHECKSUM_EN
    // Matching and mismatching trailers.
    src_q.delete();
    push_word(32'h1);
    push_word(32'h2);
    push_word(32'h3);
    do_load(2, 0, 0, cyc, to);
    finish_load(2, 0, cyc, to);
    chk("t6_ok_match",   32'(checksum_ok), 32'd1);
    chk("t6_hold_match", 32'(core_hold),   32'd0);
    idle(2);
    src_q.delete();
    push_word(32'h1);
    push_word(32'h2);
    push_word(32'h4);
    do_load(2, 0, 0, cyc, to);
    finish_load(2, 0, cyc, to);
    chk("t6_ok_mismatch",   32'(checksum_ok), 32'd0);
    chk("t6_hold_mismatch", 32'(core_hold),   32'd1);
    idle(2);
`endif

    // Randomized loads.
    for (int it = 0; it < 14; it++) begin
      wc   = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      src_q.delete();
      repeat (4 * DEPTH + 12) src_q.push_back(8'($urandom));
      do_load(wc, mode, 0, cyc, to);
      finish_load(wc, mode, cyc, to);
      idle($urandom_range(0, 3));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks_m + checks_d, errors_m + errors_d);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction fetch stage: fills the block-RAM instruction memory before the core runs.
- Receives a byte stream through a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the memory write port and holds the core's fetch path off until loading completes.

Parameters:
ADDR_WIDTH, 3, instruction memory address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
word_count  input  ADDR_WIDTH+1  number of words to load; sampled on accepted start.
byte_valid  input  1  byte_data is valid.
byte_data  input  8  incoming byte, least significant byte of each word first.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction memory write enable.
mem_addr  output  ADDR_WIDTH  word address for the write.
mem_wdata  output  32  word to write.
busy  output  1  load in progress.
done  output  1  last load completed; held until the next start.
core_hold  output  1  high keeps the core's PC and fetch stalled.

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-load):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, core_hold=1.
  - Byte and word counters clear. A partial word is discarded.
- All outputs are registered.
- IDLE:
  - On start=1, latch N = min(word_count, DEPTH).
  - If N==0, go to DONE. Otherwise go to RECV with addr=0 and byte_idx=0.
- RECV:
  - byte_ready=1 and busy=1.
  - A byte is accepted when byte_valid && byte_ready. Byte k of the word goes to bits [8k+7:8k].
  - Acceptance of the 4th byte (byte_idx==3) moves to WRITE. byte_ready deasserts in the next cycle.
  - byte_valid=0 stalls indefinitely with no timeout.
- WRITE:
  - Exactly one cycle: mem_we=1, mem_addr=addr, mem_wdata=assembled word. byte_ready=0.
  - If addr==N-1, go to DONE (or to CHECK when CHECKSUM_EN is defined). Otherwise increment addr, clear byte_idx, and return to RECV.
- DONE:
  - done=1, busy=0, core_hold=0, mem_we=0.
  - start=1 clears done, raises core_hold, and re-enters the IDLE start sequence in the same cycle (N is sampled, then RECV or DONE).
- start while busy=1 is ignored.
- Latency:
  - The first byte is accepted no earlier than the cycle after start.
  - mem_we asserts the cycle after the 4th byte is accepted.
  - done rises the cycle after the final WRITE.
  - Minimum load time is 5*N+1 cycles when byte_valid is held high.
- word_count > DEPTH saturates to DEPTH. No address wrap occurs.
- mem_addr is stable whenever mem_we=1. Its value outside WRITE is don't-care, but it must not change while mem_we=1.

Optional Feature:
CHECKSUM_EN
- Defined:
  - A 32-bit modular sum accumulates over all written words.
  - After the last WRITE, state CHECK receives 4 more bytes (same handshake, little-endian) as the expected sum.
  - Then go to DONE, with output checksum_ok (1 bit, reset 0) = (sum == expected).
  - core_hold stays 1 in DONE if checksum_ok=0.
  - N==0 still requires the trailer; expected value is 0.
- Undefined:
  - No CHECK state and no trailer.
  - checksum_ok port is absent.
  - core_hold drops in DONE unconditionally.

Test Plan:
- Reset, then start with word_count=2, bytes 13 00 00 00 93 00 10 00, byte_valid held high:
  - writes addr0=0x00000013 and addr1=0x00100093, one mem_we cycle each.
  - done=1 and core_hold=0 at cycle 11 after start.
- word_count=0:
  - done=1 the cycle after start; mem_we never asserts; byte_ready stays 0.
- word_count=12 with ADDR_WIDTH=3:
  - exactly 8 writes to addr 0..7; the 33rd byte is never accepted (byte_ready=0).
- Toggle byte_valid 1/0 each cycle for word_count=1, bytes EF BE AD DE:
  - single write of 0xDEADBEEF; byte_ready high throughout RECV.
- Assert rst after 6 of 8 bytes:
  - no further mem_we; outputs return to reset values; a new start loads from addr0 correctly.
- CHECKSUM_EN, words 0x1 and 0x2:
  - trailer 03 00 00 00 gives checksum_ok=1 and core_hold=0.
  - trailer 04 00 00 00 gives checksum_ok=0 and core_hold=1.
